serial_frame_rx: RTL

Frame receiver for the ADC serial link on the sample path. It takes the 9600-baud stream produced by the ADS7822 capture/serializer stage and locks onto each frame's ASCII '0' marker. It then reassembles the 12-bit conversion result and presents it as a parallel word with a one-cycle valid strobe. It also flags malformed frames so downstream logic and the LEDs never see corrupted samples.

---
 rtl/serial_frame_rx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Purpose: receives marker-framed 12-bit ADC samples from a serial line and presents them in parallel.
// Latency: VALID arrives 45*BIT_CLKS + BIT_CLKS/2 + 4 clocks after the marker start edge at the pin.
// Backpressure: none; VALID/FERR are single-cycle strobes and an edge arriving while BUSY is ignored.
// Ports: CLK50 clock; RST_N sync active-low reset; RXD async serial input (idles high);
//        SAMPLE/LEDS last good sample and its top byte; VALID/FERR one-cycle strobes; BUSY frame in progress.
module serial_frame_rx #(
  parameter int          BIT_CLKS = 5208,
  parameter logic [7:0]  MARKER   = 8'h30
) (
  input  logic        CLK50,
  input  logic        RST_N,
  input  logic        RXD,
  output logic [11:0] SAMPLE,
  output logic        VALID,
  output logic        FERR,
  output logic [7:0]  LEDS,
  output logic        BUSY
);

  localparam int             TW     = $clog2(BIT_CLKS);
  localparam logic [TW-1:0]  T_LAST = TW'(BIT_CLKS - 1);
  localparam logic [TW-1:0]  T_MID  = TW'(BIT_CLKS / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, RECV, DONE} state_t;

  state_t         state;
  logic           sync1, sync2, line_q;
  logic [TW-1:0]  timer;
  logic [5:0]     slot;
  logic [7:0]     mark, byte1, byte2;
  logic           fall, mid, bad;
  logic [7:0]     mark_nxt;

  // sync2 is the synchronized line; line_q is its previous value.
  assign fall     = line_q & ~sync2;
  assign mid      = (timer == T_MID);
  assign mark_nxt = {sync2, mark[7:1]};  // marker arrives LSB first

  // Per-slot frame checks, evaluated at the mid-slot sample.
  always_comb begin
    bad = 1'b0;
    case (slot)
      6'd8:                 bad = (mark_nxt != MARKER);
      6'd10, 6'd11, 6'd12:  bad = ~sync2;
      6'd27, 6'd37:         bad = sync2;
      default:              bad = 1'b0;
    endcase
  end

  // The timer runs continuously from the detected edge through START and
  // RECV, so slot n is sampled at exactly n*BIT_CLKS + BIT_CLKS/2 - 1 and
  // the slot counter always names the slot the line is currently in.
  always_ff @(posedge CLK50) begin
    if (!RST_N) begin
      state  <= IDLE;
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
      timer  <= '0;
      slot   <= '0;
      mark   <= '0;
      byte1  <= '0;
      byte2  <= '0;
      SAMPLE <= '0;
      LEDS   <= '0;
      VALID  <= 1'b0;
      FERR   <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      sync1  <= RXD;
      sync2  <= sync1;
      line_q <= sync2;
      VALID  <= 1'b0;
      FERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            timer <= '0;
            slot  <= '0;
            BUSY  <= 1'b1;
          end
        end
        START: begin
          timer <= timer + TW'(1);
          if (mid) begin
            if (sync2) begin
              // Line back high at mid start bit: glitch, drop silently.
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (slot != 6'd63) slot <= slot + 6'd1;
          end else begin
            timer <= timer + TW'(1);
          end
          if (mid) begin
            if (slot >= 6'd1 && slot <= 6'd8)   mark  <= mark_nxt;
            if (slot >= 6'd28 && slot <= 6'd35) byte1 <= {byte1[6:0], sync2};
            if (slot >= 6'd38 && slot <= 6'd45) byte2 <= {byte2[6:0], sync2};
            if (bad) begin
              FERR  <= 1'b1;
              BUSY  <= 1'b0;
              state <= IDLE;
            end else if (slot == 6'd45) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          SAMPLE <= {byte1, byte2[7:4]};
          LEDS   <= byte1;
          VALID  <= 1'b1;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
